event_collector: RTL and testbench

EVENT_COLLECTOR -- requirements
Module: event_collector

---
 rtl/event_collector.sv | 104 ++++++++++
 tb/tb_event_collector.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/event_collector.sv
// Event collector: edge/level event capture, masked pending, lowest-index grant.
// Define EVENT_COLLECTOR_LEVEL_EN for level-sensitive capture (no in_q, ovf tied low).
module event_collector #(
  parameter  int N = 2,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] in,
  input  logic [N-1:0] mask,
  output logic [N-1:0] pend,
  output logic         req,
  output logic [W-1:0] id,
  input  logic         ack,
  output logic         ovf
);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [N-1:0] pending;
  logic [N-1:0] pending_nxt;
  logic [N-1:0] evt;
  logic [N-1:0] clr;
  logic [W-1:0] id_nxt;
  logic [W-1:0] lowest;

`ifdef EVENT_COLLECTOR_LEVEL_EN
  assign evt = in;
  assign ovf = 1'b0;
`else
  logic [N-1:0] in_q;
  logic         ovf_q;

  // Delayed copy of the inputs for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) in_q <= '0;
    else        in_q <= in;
  end

  assign evt = in & ~in_q;

  // Sticky overrun: a new edge landed on a source still pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_q | (|(evt & pending));
  end

  assign ovf = ovf_q;
`endif

  assign pend = pending & mask;
  assign req  = (state == ISSUE);

  // Lowest enabled pending index; fixed priority, no rotation.
  always_comb begin
    lowest = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pend[i]) lowest = W'(i);
    end
  end

  // Grant FSM: pick in IDLE, hold id/req until ack in ISSUE.
  always_comb begin
    state_nxt = state;
    id_nxt    = id;
    clr       = '0;
    unique case (state)
      IDLE: begin
        if (|pend) begin
          state_nxt = ISSUE;
          id_nxt    = lowest;
        end
      end
      ISSUE: begin
        if (ack) begin
          state_nxt = IDLE;
          clr[id]   = 1'b1;
        end
      end
    endcase
  end

  // Set wins over the grant clear on the same source.
  assign pending_nxt = (pending & ~clr) | evt;

  // State, grant index and pending vector registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      id      <= '0;
      pending <= '0;
    end else begin
      state   <= state_nxt;
      id      <= id_nxt;
      pending <= pending_nxt;
    end
  end

endmodule

// File: tb/tb_event_collector.sv
// Bench for event_collector (N=4, edge mode).
// Directed scenarios plus random traffic against a behavioural model.
module tb_event_collector;

  logic       clk;
  logic       rst_n;
  logic [3:0] in_v;
  logic [3:0] mask;
  logic [3:0] pend;
  logic       req;
  logic [1:0] id;
  logic       ack;
  logic       ovf;

  int n_assert;
  int n_fail;

  logic [3:0] m_pend;
  logic [3:0] m_prev;
  logic       m_busy;
  logic [1:0] m_gid;
  logic       m_ovf;

  event_collector #(.N(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .in   (in_v),
    .mask (mask),
    .pend (pend),
    .req  (req),
    .id   (id),
    .ack  (ack),
    .ovf  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = '0;
    m_prev = '0;
    m_busy = 1'b0;
    m_gid  = '0;
    m_ovf  = 1'b0;
  endtask

  // One clock edge of the service rules, using pre-edge values.
  task automatic model_edge();
    logic [3:0] evt;
    logic [3:0] old;
    logic       found;
    old   = m_pend;
    evt   = in_v & ~m_prev;
    found = 1'b0;
    for (int i = 0; i < 4; i++)
      if (evt[i] && old[i]) m_ovf = 1'b1;
    if (m_busy) begin
      if (ack) begin
        m_pend[m_gid] = 1'b0;
        m_busy        = 1'b0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!found && old[i] && mask[i]) begin
          found  = 1'b1;
          m_busy = 1'b1;
          m_gid  = 2'(i);
        end
      end
    end
    m_pend = m_pend | evt;
    m_prev = in_v;
  endtask

  task automatic check_all(string tag);
    check({tag, ".pend"}, 32'(pend), 32'(m_pend & mask));
    check({tag, ".req"},  32'(req),  32'(m_busy));
    check({tag, ".id"},   32'(id),   32'(m_gid));
    check({tag, ".ovf"},  32'(ovf),  32'(m_ovf));
  endtask

  task automatic cycle(string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic reset_cycle();
    @(posedge clk);
    #1;
    check("rst.pend", 32'(pend), 32'h0);
    check("rst.req",  32'(req),  32'h0);
    check("rst.id",   32'(id),   32'h0);
    check("rst.ovf",  32'(ovf),  32'h0);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    in_v     = '0;
    mask     = 4'hF;
    ack      = 1'b0;
    model_reset();

    #2;
    check("init.pend", 32'(pend), 32'h0);
    check("init.req",  32'(req),  32'h0);
    check("init.id",   32'(id),   32'h0);
    check("init.ovf",  32'(ovf),  32'h0);
    reset_cycle();
    #2 rst_n = 1'b1;
    cycle("idle");

    // Single pulse on source 2, ack held low.
    in_v = 4'b0100;
    cycle("p2.set");
    check("p2.pend", 32'(pend), 32'h4);
    check("p2.req0", 32'(req),  32'h0);
    in_v = 4'b0000;
    cycle("p2.grant");
    check("p2.req",  32'(req),  32'h1);
    check("p2.id",   32'(id),   32'h2);
    for (int k = 0; k < 10; k++) cycle("p2.hold");
    check("p2.held", 32'(req),  32'h1);
    ack = 1'b1;
    cycle("p2.ack");
    ack = 1'b0;
    cycle("p2.done");

    // Two simultaneous rises, granted lowest first.
    in_v = 4'b1010;
    cycle("two.set");
    check("two.pend", 32'(pend), 32'hA);
    in_v = 4'b0000;
    cycle("two.g1");
    check("two.id1", 32'(id), 32'h1);
    ack = 1'b1;
    cycle("two.a1");
    check("two.gap", 32'(req), 32'h0);
    ack = 1'b0;
    cycle("two.g3");
    check("two.id3", 32'(id), 32'h3);
    ack = 1'b1;
    cycle("two.a3");
    ack = 1'b0;
    cycle("two.end");
    check("two.pend0", 32'(pend), 32'h0);

    // Masked source accumulates, then unmasked.
    mask = 4'b1110;
    in_v = 4'b0001;
    cycle("msk.set");
    in_v = 4'b0000;
    cycle("msk.quiet");
    check("msk.req0", 32'(req), 32'h0);
    mask = 4'hF;
    #1 check("msk.pend", 32'(pend), 32'h1);
    cycle("msk.grant");
    check("msk.id0", 32'(id), 32'h0);
    ack = 1'b1;
    cycle("msk.ack");
    ack = 1'b0;
    cycle("msk.done");

    // Re-rise on the granted source in the ack cycle.
    in_v = 4'b0010;
    cycle("ovf.set");
    in_v = 4'b0000;
    cycle("ovf.grant");
    in_v = 4'b0010;
    ack  = 1'b1;
    cycle("ovf.collide");
    check("ovf.flag", 32'(ovf),  32'h1);
    check("ovf.keep", 32'(pend), 32'h2);
    in_v = 4'b0000;
    ack  = 1'b0;
    cycle("ovf.regrant");
    check("ovf.id1", 32'(id), 32'h1);
    ack = 1'b1;
    cycle("ovf.ack");
    ack = 1'b0;

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      in_v = 4'($urandom);
      mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      ack  = ($urandom_range(0, 2) == 0);
      cycle("rnd");
    end

    // Async reset mid-grant, in[3] held through release.
    mask = 4'hF;
    ack  = 1'b0;
    in_v = 4'b0000;
    cycle("ar.clr");
    in_v = 4'b0100;
    cycle("ar.set");
    in_v = 4'b0000;
    cycle("ar.pre");
    if (!m_busy) cycle("ar.pre2");
    check("ar.busy", 32'(req), 32'h1);
    in_v = 4'b1000;
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check("ar.pend", 32'(pend), 32'h0);
    check("ar.req",  32'(req),  32'h0);
    check("ar.id",   32'(id),   32'h0);
    check("ar.ovf",  32'(ovf),  32'h0);
    reset_cycle();
    #2 rst_n = 1'b1;
    cycle("ar.e1");
    check("ar.e1pend", 32'(pend), 32'h8);
    cycle("ar.e2");
    check("ar.req3", 32'(req), 32'h1);
    check("ar.id3",  32'(id),  32'h3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
